// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK
    } load_state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles four received bytes into a little-endian 32-bit word.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic        consume,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last,
    output logic        full
);

    logic [1:0] pos;

    // Shifting in from the top leaves the first byte in bits 7:0 after four shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos  <= '0;
            word <= '0;
            full <= 1'b0;
        end else if (clear) begin
            pos  <= '0;
            full <= 1'b0;
        end else begin
            if (shift) begin
                word <= {byte_in, word[31:8]};
                pos  <= pos + 2'd1;
                if (pos == 2'd3) begin
                    full <= 1'b1;
                end
            end
            if (consume) begin
                full <= 1'b0;
            end
        end
    end

    assign last = (pos == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: count byte, packed instruction words, XOR checksum.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = imem_pkg::DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        Busy,
    output logic        Done,
    output logic        ChkErr
);

    localparam int unsigned IW = AW + 1;

    load_state_t   state, state_next;
    logic [IW-1:0] n_words;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [7:0]    xor_sum;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [31:0]   write_addr;
    logic [31:0]   word;
    logic          last;
    logic          full;
    logic          rx_ready;
    logic          accept;

    assign accept     = RxValid && rx_ready;
    assign idx_inc    = idx + 1'b1;
    assign write_addr = 32'({idx, 2'b00});

    word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_IDLE && Start),
        .shift   (state == S_DATA && accept),
        .consume (state == S_WRITE),
        .byte_in (RxData),
        .word    (word),
        .last    (last),
        .full    (full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start) state_next = S_COUNT;
            end
            S_COUNT: begin
                rx_ready = 1'b1;
                if (RxValid) state_next = S_DATA;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (RxValid && last) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = (idx_inc == n_words) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                rx_ready = 1'b1;
                if (RxValid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words <= '0;
            idx     <= '0;
            xor_sum <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            Done    <= 1'b0;
            ChkErr  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        Done    <= 1'b0;
                        ChkErr  <= 1'b0;
                        xor_sum <= '0;
                        idx     <= '0;
                    end
                end
                S_COUNT: begin
                    idx <= '0;
                    if (accept) begin
                        n_words <= (RxData == 8'd0) ? IW'(DEPTH) : IW'(RxData);
                    end
                end
                S_DATA: begin
                    if (accept) xor_sum <= xor_sum ^ RxData;
                end
                S_WRITE: begin
                    idx    <= idx_inc;
                    addr_q <= write_addr;
                    data_q <= word;
                end
                S_CHECK: begin
                    if (accept) begin
                        Done   <= 1'b1;
                        ChkErr <= (RxData != xor_sum);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs show the live write during WRITE and otherwise replay the last one.
    assign MemWE    = (state == S_WRITE) && full;
    assign MemAddr  = MemWE ? write_addr : addr_q;
    assign MemWData = MemWE ? word : data_q;
    assign RxReady  = rx_ready;
    assign Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: write scoreboard plus table-driven loads.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        Busy;
    logic        Done;
    logic        ChkErr;

    imem_loader #(.DEPTH(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .MemWE    (MemWE),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .Busy     (Busy),
        .Done     (Done),
        .ChkErr   (ChkErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] seed;
        bit         bad;
        bit         rnd;
        bit         exp_err;
    } vec_t;

    wr_t         exp_q[$];
    logic [7:0]  dbytes[$];
    vec_t        vecs[4];
    int unsigned comps = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        comps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && MemWE) begin
            if (exp_q.size() == 0) begin
                comps++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", MemAddr, MemWData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", MemAddr, e.addr);
                chk("write_data", MemWData, e.data);
                chk("rxready_in_write", 32'(RxReady), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit ok;
        int unsigned guard;
        guard = 0;
        ok = 1'b0;
        if (rnd) begin
            int unsigned gap;
            gap = $urandom_range(0, 2);
            for (int unsigned g = 0; g < gap; g++) begin
                RxValid = 1'b0;
                @(posedge clk); #1;
            end
        end
        RxData  = b;
        RxValid = 1'b1;
        do begin
            ok = RxReady;
            @(posedge clk); #1;
            guard++;
        end while (!ok && guard < 64);
        if (!ok) begin
            comps++;
            fails++;
            $display("FAIL handshake_timeout: got no RxReady in %0d cycles expected acceptance", guard);
        end
        RxValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    function automatic logic [7:0] xor_of_data();
        logic [7:0] x;
        x = '0;
        foreach (dbytes[i]) x ^= dbytes[i];
        return x;
    endfunction

    // Runs one full load of dbytes; expected writes go to the scoreboard as each word is sent.
    task automatic run_load(input logic [7:0] cnt, input logic [7:0] chksum, input bit rnd,
                            input bit exp_err, input bit mid_start);
        int unsigned t0;
        int unsigned nw;
        logic [31:0] w;
        nw = dbytes.size() / 4;
        w  = '0;
        t0 = cyc;
        pulse_start();
        chk("busy_after_start", 32'(Busy), 32'd1);
        chk("done_cleared", 32'(Done), 32'd0);
        send_byte(cnt, rnd);
        for (int unsigned i = 0; i < dbytes.size(); i++) begin
            w[(i % 4) * 8 +: 8] = dbytes[i];
            if (i % 4 == 3) exp_q.push_back('{addr: 32'((i / 4) * 4), data: w});
            if (mid_start && i == 2) pulse_start();
            send_byte(dbytes[i], rnd);
        end
        send_byte(chksum, rnd);
        chk("done", 32'(Done), 32'd1);
        chk("chkerr", 32'(ChkErr), 32'(exp_err));
        chk("busy_end", 32'(Busy), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        if (!rnd && !mid_start) chk("load_cycles", cyc - t0, 3 + 5 * nw);
    endtask

    task automatic load_ref_bytes();
        logic [7:0] ref_bytes[8];
        ref_bytes = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
        dbytes.delete();
        foreach (ref_bytes[i]) dbytes.push_back(ref_bytes[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Start = 1'b0; RxData = '0; RxValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rxready", 32'(RxReady), 32'd0);
        chk("rst_memwe", 32'(MemWE), 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_chkerr", 32'(ChkErr), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reference program, good checksum
        load_ref_bytes();
        chk("ref_xor", 32'(xor_of_data()), 32'h10);
        run_load(8'h02, 8'h10, 1'b0, 1'b0, 1'b0);
        chk("hold_addr", MemAddr, 32'h4);
        chk("hold_data", MemWData, 32'h00C00193);

        // Same program, wrong checksum
        run_load(8'h02, 8'h11, 1'b0, 1'b1, 1'b0);

        // Random RxValid gaps, valid held high across WRITE
        run_load(8'h02, 8'h10, 1'b1, 1'b0, 1'b0);

        // Start pulsed mid-data is ignored
        run_load(8'h02, 8'h10, 1'b0, 1'b0, 1'b1);

        vecs[0] = '{cnt: 8'd1, seed: 8'h11, bad: 1'b0, rnd: 1'b0, exp_err: 1'b0};
        vecs[1] = '{cnt: 8'd3, seed: 8'h5A, bad: 1'b1, rnd: 1'b0, exp_err: 1'b1};
        vecs[2] = '{cnt: 8'd4, seed: 8'h00, bad: 1'b0, rnd: 1'b1, exp_err: 1'b0};
        vecs[3] = '{cnt: 8'd2, seed: 8'hF0, bad: 1'b1, rnd: 1'b1, exp_err: 1'b1};
        for (int v = 0; v < 4; v++) begin
            logic [7:0] cs;
            dbytes.delete();
            for (int unsigned k = 0; k < 4 * 32'(vecs[v].cnt); k++)
                dbytes.push_back(vecs[v].seed + 8'(k * 37));
            cs = xor_of_data() ^ (vecs[v].bad ? 8'h01 : 8'h00);
            run_load(vecs[v].cnt, cs, vecs[v].rnd, vecs[v].exp_err, 1'b0);
        end

        // Full-depth load via count byte 0
        dbytes.delete();
        for (int unsigned k = 0; k < 1024; k++) dbytes.push_back(8'hAA);
        run_load(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("full_last_addr", MemAddr, 32'h3FC);
        chk("full_last_data", MemWData, 32'hAAAAAAAA);

        // Reset after six data bytes: only the first word is written
        load_ref_bytes();
        pulse_start();
        send_byte(8'h02, 1'b0);
        exp_q.push_back('{addr: 32'h0, data: 32'h00500113});
        for (int unsigned i = 0; i < 6; i++) send_byte(dbytes[i], 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rxready", 32'(RxReady), 32'd0);
        chk("midrst_memwe", 32'(MemWE), 32'd0);
        chk("midrst_addr", MemAddr, 32'd0);
        chk("midrst_wdata", MemWData, 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_chkerr", 32'(ChkErr), 32'd0);
        chk("midrst_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_load(8'h02, 8'h10, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_no_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
